// File: rtl/des_sweep_sequencer_if.sv
// des_sweep_sequencer_if: bundles the two channels of the sweep sequencer.
//   Command channel (sequencer -> DES wrapper): cmd, cmd_valid, region, and
//   the wrapper's responses cmd_read, done, counter, ciphertext.
//   Result channel (sequencer -> consumer): res_valid/res_ready handshake
//   carrying res_region, res_counter, res_ciphertext, res_cycles.
// master = sequencer side, slave = wrapper/consumer side.
interface des_sweep_sequencer_if #(
    parameter int unsigned CYC_W = 32
) ();
    // command channel
    logic [31:0]      cmd;
    logic             cmd_valid;
    logic [31:0]      region;
    logic             cmd_read;
    logic             done;
    logic [63:0]      counter;
    logic [63:0]      ciphertext;

    // result channel
    logic             res_valid;
    logic             res_ready;
    logic [15:0]      res_region;
    logic [63:0]      res_counter;
    logic [63:0]      res_ciphertext;
    logic [CYC_W-1:0] res_cycles;

    modport master (
        output cmd, cmd_valid, region,
        input  cmd_read, done, counter, ciphertext,
        output res_valid, res_region, res_counter, res_ciphertext, res_cycles,
        input  res_ready
    );

    modport slave (
        input  cmd, cmd_valid, region,
        output cmd_read, done, counter, ciphertext,
        input  res_valid, res_region, res_counter, res_ciphertext, res_cycles,
        output res_ready
    );
endinterface

// File: rtl/des_sweep_sequencer.sv
// des_sweep_sequencer: sweeps regions first_region..last_region (inclusive).
// For each region it issues READ_REGION, START, waits for done, captures the
// wrapper's counter/ciphertext, issues RESTART, then hands one result record
// to the consumer. All outputs are registered.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, abort      sweep control (start sampled in IDLE, abort sticky)
//   first_region,
//   last_region       sweep range, sampled on accepted start
//   busy, sweep_done  status; sweep_done is a one-cycle end pulse
//   bus               command channel to the wrapper + result channel
module des_sweep_sequencer #(
    parameter int unsigned CYC_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [15:0]           first_region,
    input  logic [15:0]           last_region,
    output logic                  busy,
    output logic                  sweep_done,
    des_sweep_sequencer_if.master bus
);

    localparam logic [31:0]      CMD_READ_REGION = 32'd0;
    localparam logic [31:0]      CMD_START       = 32'd1;
    localparam logic [31:0]      CMD_RESTART     = 32'd3;
    localparam logic [CYC_W-1:0] CYC_MAX         = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_REGION,
        S_SEND_START,
        S_WAIT_DONE,
        S_CAPTURE,
        S_SEND_RESTART,
        S_RESULT,
        S_FINISH
    } state_t;

    state_t           state;
    logic [15:0]      cur;
    logic [15:0]      last;
    logic             abort_q;
    logic [CYC_W-1:0] cyc;

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= S_IDLE;
            cur                <= '0;
            last               <= '0;
            abort_q            <= 1'b0;
            cyc                <= '0;
            busy               <= 1'b0;
            sweep_done         <= 1'b0;
            bus.cmd            <= '0;
            bus.cmd_valid      <= 1'b0;
            bus.region         <= '0;
            bus.res_valid      <= 1'b0;
            bus.res_region     <= '0;
            bus.res_counter    <= '0;
            bus.res_ciphertext <= '0;
            bus.res_cycles     <= '0;
        end else begin
            sweep_done <= 1'b0;

            // Abort only takes effect at the RESULT decision, so the region
            // in flight always completes.
            if (state != S_IDLE && abort) begin
                abort_q <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        cur  <= first_region;
                        last <= last_region;
                        if (first_region > last_region) begin
                            state <= S_FINISH;
                        end else begin
                            bus.region    <= {16'h0, first_region};
                            bus.cmd       <= CMD_READ_REGION;
                            bus.cmd_valid <= 1'b1;
                            state         <= S_SEND_REGION;
                        end
                    end
                end

                S_SEND_REGION: begin
                    if (bus.cmd_read) begin
                        bus.cmd_valid <= 1'b0;
                        state         <= S_SEND_START;
                    end
                end

                // Entered with cmd_valid low: one idle cycle between commands.
                S_SEND_START: begin
                    if (!bus.cmd_valid) begin
                        bus.cmd       <= CMD_START;
                        bus.cmd_valid <= 1'b1;
                    end else if (bus.cmd_read) begin
                        bus.cmd_valid <= 1'b0;
                        cyc           <= '0;
                        state         <= S_WAIT_DONE;
                    end
                end

                // done edge counts too; CAPTURE gives the wrapper's counter
                // register one more cycle to load.
                S_WAIT_DONE: begin
                    if (cyc != CYC_MAX) begin
                        cyc <= cyc + CYC_W'(1);
                    end
                    if (bus.done) begin
                        state <= S_CAPTURE;
                    end
                end

                S_CAPTURE: begin
                    bus.res_region     <= cur;
                    bus.res_counter    <= bus.counter;
                    bus.res_ciphertext <= bus.ciphertext;
                    bus.res_cycles     <= cyc;
                    bus.cmd            <= CMD_RESTART;
                    bus.cmd_valid      <= 1'b1;
                    state              <= S_SEND_RESTART;
                end

                S_SEND_RESTART: begin
                    if (bus.cmd_read) begin
                        bus.cmd_valid <= 1'b0;
                        bus.res_valid <= 1'b1;
                        state         <= S_RESULT;
                    end
                end

                // Compare before increment so last=FFFF never wraps cur.
                S_RESULT: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        if (abort_q || cur == last) begin
                            state <= S_FINISH;
                        end else begin
                            cur           <= 16'(cur + 16'd1);
                            bus.region    <= {16'h0, 16'(cur + 16'd1)};
                            bus.cmd       <= CMD_READ_REGION;
                            bus.cmd_valid <= 1'b1;
                            state         <= S_SEND_REGION;
                        end
                    end
                end

                // busy stays high through the sweep_done cycle; IDLE drops it.
                S_FINISH: begin
                    sweep_done <= 1'b1;
                    abort_q    <= 1'b0;
                    state      <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_des_sweep_sequencer.sv
// Testbench for des_sweep_sequencer: a wrapper model answers commands with
// random read delays and latencies, a consumer applies ready policies, and
// each sweep is compared against the command/record list expected from the
// range, abort point and latencies.
module tb_des_sweep_sequencer;

    localparam int unsigned CYC_W   = 6;
    localparam int          CYC_MAX = (1 << CYC_W) - 1;
    localparam logic [63:0] GARBAGE = 64'hBAD0_BAD0_BAD0_BAD0;

    typedef struct packed {
        logic [31:0] cmd;
        logic [31:0] region;
    } cmd_t;

    typedef struct packed {
        logic [15:0]      region;
        logic [63:0]      counter;
        logic [63:0]      ct;
        logic [CYC_W-1:0] cycles;
    } rec_t;

    typedef struct {
        logic [15:0] first;
        logic [15:0] last;
        int          abort_reg;   // region whose START triggers abort, -1 none
        int          rdy_mode;    // 0 always ready, 1 random, 2 hold low 10 cycles
        int          fixed_lat;   // 0 = random latency
        logic [63:0] ctr_val;
        int          exp_recs;    // -1 = not tabulated
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort;
    logic [15:0] first_region = '0;
    logic [15:0] last_region = '0;
    logic        busy;
    logic        sweep_done;

    des_sweep_sequencer_if #(.CYC_W(CYC_W)) bus ();

    des_sweep_sequencer #(.CYC_W(CYC_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .first_region (first_region),
        .last_region  (last_region),
        .busy         (busy),
        .sweep_done   (sweep_done),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          cur_abort_reg = -1;
    int          cur_rdy_mode = 0;
    int          cur_fixed_lat = 0;
    logic [63:0] cur_ctr = '0;
    logic        abort_idle = 1'b0;
    cmd_t        cmd_log[$];
    rec_t        rec_log[$];
    int          lat_of[int];
    int          hold_err = 0;
    int          done_total = 0;

    function automatic logic [63:0] ct_of(input logic [15:0] r);
        return {r, 16'hC0DE, ~r, 16'h5A5A};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wrapper model: takes commands after 0..2 cycles, raises done L cycles
    // after START, counter valid from the 2nd done cycle, done drops on RESTART.
    initial begin : wrapper_model
        cmd_t        seen;
        int          run;
        int          rd_delay;
        int          abort_hold;
        logic [15:0] act_reg;
        seen = '0; run = 0; rd_delay = 0; abort_hold = 0; act_reg = '0;
        bus.cmd_read = 1'b0; bus.done = 1'b0; bus.counter = GARBAGE;
        bus.ciphertext = '0; abort = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.cmd_read = 1'b0; bus.done = 1'b0; bus.counter = GARBAGE;
                run = 0; rd_delay = 0; abort_hold = 0;
            end else begin
                if (bus.cmd_read) begin
                    bus.cmd_read = 1'b0;
                    cmd_log.push_back(seen);
                    rd_delay = int'($urandom_range(0, 2));
                    if (seen.cmd == 32'd0) begin
                        act_reg = seen.region[15:0];
                    end else if (seen.cmd == 32'd1) begin
                        run = (cur_fixed_lat > 0) ? cur_fixed_lat : int'($urandom_range(1, 25));
                        lat_of[int'(act_reg)] = run;
                        if (int'(act_reg) == cur_abort_reg) abort_hold = 3;
                    end else if (seen.cmd == 32'd3) begin
                        bus.done = 1'b0;
                        bus.counter = GARBAGE;
                    end
                end else if (bus.cmd_valid) begin
                    if (rd_delay == 0) begin
                        bus.cmd_read = 1'b1;
                        seen.cmd = bus.cmd;
                        seen.region = bus.region;
                    end else begin
                        rd_delay--;
                    end
                end
                if (run > 0) begin
                    run--;
                    if (run == 0) begin
                        bus.done = 1'b1;
                        bus.ciphertext = ct_of(act_reg);
                    end
                end else if (bus.done) begin
                    bus.counter = cur_ctr;
                end
                if (abort_hold > 0) abort_hold--;
            end
            abort = abort_idle || (abort_hold > 0);
        end
    end

    // Consumer: applies the ready policy, logs transferred records and
    // counts hold violations (record changing, valid lingering, cmd overlap).
    initial begin : consumer
        rec_t snap;
        rec_t now_rec;
        logic prev_valid;
        logic prev_xfer;
        int   bp;
        snap = '0; prev_valid = 1'b0; prev_xfer = 1'b0; bp = 0;
        bus.res_ready = 1'b0;
        forever begin
            @(negedge clk);
            now_rec = {bus.res_region, bus.res_counter, bus.res_ciphertext, bus.res_cycles};
            if (rst) begin
                bus.res_ready = 1'b0; prev_valid = 1'b0; prev_xfer = 1'b0; bp = 0;
            end else begin
                if (prev_xfer && bus.res_valid) hold_err++;
                if (bus.res_valid && prev_valid && !prev_xfer && now_rec !== snap) hold_err++;
                if (bus.res_valid && bus.cmd_valid) hold_err++;
                snap = now_rec;
                prev_valid = bus.res_valid;
                prev_xfer = 1'b0;
                case (cur_rdy_mode)
                    0: bus.res_ready = 1'b1;
                    1: bus.res_ready = 1'($urandom_range(0, 1));
                    default: begin
                        if (bus.res_valid && bp < 10) begin
                            bus.res_ready = 1'b0;
                            bp++;
                        end else begin
                            bus.res_ready = 1'b1;
                        end
                    end
                endcase
                if (bus.res_valid && bus.res_ready) begin
                    rec_log.push_back(now_rec);
                    prev_xfer = 1'b1;
                    bp = 0;
                end
            end
        end
    end

    initial begin : done_monitor
        forever begin
            @(negedge clk);
            if (sweep_done === 1'b1) done_total++;
        end
    end

    task automatic run_vec(input int idx, input vec_t v);
        int   regs[$];
        int   r;
        int   n;
        int   bad;
        int   lat;
        int   cbase;
        int   rbase;
        int   dbase;
        int   hbase;
        logic [31:0] ecmd;
        rec_t got;
        cur_abort_reg = v.abort_reg;
        cur_rdy_mode  = v.rdy_mode;
        cur_fixed_lat = v.fixed_lat;
        cur_ctr       = v.ctr_val;
        // abort while idle must be ignored
        abort_idle = 1'b1;
        repeat (2) @(negedge clk);
        abort_idle = 1'b0;
        repeat (2) @(negedge clk);
        cbase = cmd_log.size(); rbase = rec_log.size();
        dbase = done_total; hbase = hold_err;
        first_region = v.first; last_region = v.last; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check($sformatf("v%0d busy_after_start", idx), 64'(busy), 64'd1);
        if (v.first > v.last) begin
            check($sformatf("v%0d empty_n1", idx), 64'({sweep_done, bus.cmd_valid}), 64'd0);
            @(negedge clk);
            check($sformatf("v%0d empty_n2", idx), 64'({busy, sweep_done, bus.cmd_valid}), 64'b110);
            @(negedge clk);
            check($sformatf("v%0d empty_n3", idx), 64'({busy, sweep_done}), 64'd0);
        end else begin
            check($sformatf("v%0d first_cmd", idx), 64'({bus.cmd_valid, bus.cmd}), 64'({1'b1, 32'd0}));
            check($sformatf("v%0d first_region", idx), 64'(bus.region), 64'({16'h0, v.first}));
            repeat (3) @(negedge clk);
            start = 1'b1;   // must be ignored while busy
            @(negedge clk);
            start = 1'b0;
            n = 0;
            while (sweep_done !== 1'b1 && n < 4000) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("v%0d sweep_end_seen", idx), 64'(n < 4000), 64'd1);
            @(negedge clk);
            check($sformatf("v%0d idle_after_done", idx), 64'({busy, sweep_done}), 64'd0);
        end
        repeat (3) @(negedge clk);
        check($sformatf("v%0d sweep_done_pulses", idx), 64'(done_total - dbase), 64'd1);
        check($sformatf("v%0d still_idle", idx), 64'({busy, bus.cmd_valid, bus.res_valid}), 64'd0);
        check($sformatf("v%0d hold_violations", idx), 64'(hold_err - hbase), 64'd0);

        // reference: regions first..last, stopping after the abort region
        if (v.first <= v.last) begin
            r = int'(v.first);
            forever begin
                regs.push_back(r);
                if (r == v.abort_reg || r == int'(v.last)) break;
                r++;
            end
        end
        if (v.exp_recs >= 0)
            check($sformatf("v%0d table_records", idx), 64'(rec_log.size() - rbase), 64'(v.exp_recs));
        check($sformatf("v%0d num_records", idx), 64'(rec_log.size() - rbase), 64'(regs.size()));
        check($sformatf("v%0d num_cmds", idx), 64'(cmd_log.size() - cbase), 64'(3 * regs.size()));
        bad = 0;
        for (int i = 0; i < 3 * regs.size() && cbase + i < cmd_log.size(); i++) begin
            ecmd = (i % 3 == 0) ? 32'd0 : (i % 3 == 1) ? 32'd1 : 32'd3;
            if (cmd_log[cbase + i].cmd !== ecmd) bad++;
            if (i % 3 == 0 && cmd_log[cbase + i].region !== {16'h0, 16'(regs[i / 3])}) bad++;
        end
        check($sformatf("v%0d cmd_sequence_errs", idx), 64'(bad), 64'd0);
        for (int i = 0; i < regs.size() && rbase + i < rec_log.size(); i++) begin
            got = rec_log[rbase + i];
            lat = lat_of.exists(regs[i]) ? lat_of[regs[i]] : -1;
            if (lat > CYC_MAX) lat = CYC_MAX;
            check($sformatf("v%0d rec%0d region", idx, i), 64'(got.region), 64'(regs[i]));
            check($sformatf("v%0d rec%0d counter", idx, i), got.counter, v.ctr_val);
            check($sformatf("v%0d rec%0d ciphertext", idx, i), got.ct, ct_of(16'(regs[i])));
            check($sformatf("v%0d rec%0d cycles", idx, i), 64'(got.cycles), 64'(lat));
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t vecs[8];
        vec_t rv;
        vec_t clean;
        int   n;
        int   len;
        int   base;
        vecs[0] = '{16'h0005, 16'h0005, -1, 0, 20, 64'h1234, 1};
        vecs[1] = '{16'h0002, 16'h0004, -1, 0, 0, 64'h1111_2222_3333_4444, 3};
        vecs[2] = '{16'h0008, 16'h0009, -1, 2, 0, 64'hFEED, 2};
        vecs[3] = '{16'h0002, 16'h0006, 3, 1, 0, 64'h5555, 2};
        vecs[4] = '{16'hFFFE, 16'hFFFF, -1, 1, 0, 64'hA5A5, 2};
        vecs[5] = '{16'h0007, 16'h0003, -1, 0, 0, 64'h0, 0};
        vecs[6] = '{16'h000A, 16'h000D, -1, 1, 0, 64'h77, 4};
        vecs[7] = '{16'h0009, 16'h0009, -1, 0, 70, 64'h99, 1};

        // reset values
        repeat (2) @(negedge clk);
        check("reset_ctrl", 64'({busy, sweep_done, bus.cmd_valid, bus.res_valid}), 64'd0);
        check("reset_cmd", 64'(bus.cmd), 64'd0);
        check("reset_region", 64'(bus.region), 64'd0);
        check("reset_res", 64'({bus.res_region, bus.res_cycles}), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        for (int k = 0; k < 4; k++) begin
            rv.first = 16'($urandom_range(0, 65535));
            len = int'($urandom_range(0, 3));
            rv.last = (int'(rv.first) + len > 65535) ? 16'hFFFF : 16'(int'(rv.first) + len);
            if (k == 3) begin
                rv.last = rv.first;
                rv.first = 16'(rv.first + 16'd1);
                if (rv.first == 16'h0) rv.first = 16'h0001;
                if (rv.first <= rv.last) rv.last = 16'h0000;
            end
            rv.abort_reg = ($urandom_range(0, 1) == 1) ? int'(rv.first) + int'($urandom_range(0, 3)) : -1;
            rv.rdy_mode = 1;
            rv.fixed_lat = 0;
            rv.ctr_val = {$urandom, $urandom};
            rv.exp_recs = -1;
            run_vec(10 + k, rv);
        end

        // async reset in the middle of WAIT_DONE for region 21
        cur_abort_reg = -1; cur_rdy_mode = 0; cur_fixed_lat = 15; cur_ctr = 64'hABCD;
        base = cmd_log.size();
        first_region = 16'd20; last_region = 16'd25; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (cmd_log.size() < base + 5 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("rst_reached_wait", 64'(cmd_log.size() >= base + 5), 64'd1);
        repeat (3) @(negedge clk);
        check("rst_pre_res_region", 64'(bus.res_region), 64'd20);
        #2 rst = 1'b1;
        #1;
        check("rst_async_ctrl", 64'({busy, sweep_done, bus.cmd_valid, bus.res_valid}), 64'd0);
        check("rst_async_cmd", 64'(bus.cmd), 64'd0);
        check("rst_async_region", 64'(bus.region), 64'd0);
        check("rst_async_res_region", 64'(bus.res_region), 64'd0);
        check("rst_async_res_counter", bus.res_counter, 64'd0);
        check("rst_async_res_ct", bus.res_ciphertext, 64'd0);
        check("rst_async_res_cycles", 64'(bus.res_cycles), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        clean = '{16'h001E, 16'h001F, -1, 1, 0, 64'hC1EA, 2};
        run_vec(20, clean);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/des_sweep_sequencer.md
# des_sweep_sequencer

Upstream command sequencer for the DES block wrapper. It sweeps a programmable range of 16-bit regions. For each region it runs the wrapper's command sequence: region load, start, wait for done, capture, restart. It then presents one result record per region to a downstream consumer through a valid/ready handshake. This replaces CPU-driven per-region command issue.

## Interface
Parameters
- CYC_W, default 32: width of the per-region cycle counter (saturating).

Ports
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a sweep; sampled only in IDLE.
- abort  in  1  stop after the region currently in flight; sticky until the sweep ends.
- first_region  in  16  first region, sampled on accepted start.
- last_region  in  16  last region (inclusive), sampled on accepted start.
- busy  out  1  high from the cycle after an accepted start until the return to IDLE.
- sweep_done  out  1  one-cycle pulse when the sweep ends, whether normally, by abort, or as an empty range.
- cmd  out  32  command to wrapper: 0 = READ_REGION, 1 = START, 3 = RESTART.
- cmd_valid  out  1  command valid; level, held until cmd_read.
- region  out  32  {16'h0, current region}.
- cmd_read  in  1  wrapper has consumed the command.
- done  in  1  wrapper finished; level.
- counter  in  64  wrapper counter result; valid from the 2nd consecutive cycle of done.
- ciphertext  in  64  wrapper ciphertext, registered by the wrapper.
- res_valid  out  1  result record valid.
- res_ready  in  1  consumer accepts the record.
- res_region  out  16  region of the record.
- res_counter  out  64  captured counter.
- res_ciphertext  out  64  captured ciphertext.
- res_cycles  out  CYC_W  cycles spent in WAIT_DONE for this region; saturates at all-ones.

## Operation
- States: IDLE, SEND_REGION, SEND_START, WAIT_DONE, CAPTURE, SEND_RESTART, RESULT, FINISH.
- IDLE, start=1:
  - Latch first/last region into cur/last registers.
  - If first_region > last_region (empty range), go to FINISH directly.
  - Otherwise go to SEND_REGION.
- SEND_REGION: cmd=0, cmd_valid=1, region=cur. On cmd_read=1, deassert cmd_valid at that edge and go to SEND_START.
- SEND_START: cmd=1, cmd_valid=1. On cmd_read, clear the cycle counter and go to WAIT_DONE.
- WAIT_DONE:
  - Cycle counter increments each cycle, saturating.
  - On done=1, go to CAPTURE. This adds one wait cycle so the wrapper's counter register is loaded.
- CAPTURE:
  - Register counter, ciphertext, cur and the cycle count into the res_* registers.
  - Go to SEND_RESTART.
- SEND_RESTART: cmd=3, cmd_valid=1. On cmd_read, go to RESULT.
- RESULT: res_valid=1, with res_* stable while valid. On res_ready=1:
  - If abort is latched or cur==last, go to FINISH.
  - Otherwise cur <= cur+1 and go to SEND_REGION.
- FINISH: sweep_done=1 for one cycle, clear the abort latch, then go to IDLE.
- Compare-before-increment: last_region=16'hFFFF never wraps cur to 0, and the sweep ends after region FFFF.
- Abort:
  - Latched in any non-IDLE state.
  - Never interrupts WAIT_DONE, because the wrapper ignores RESTART while running.
  - The in-flight region always completes and its result is delivered.
  - abort in IDLE is ignored.
- start while busy is ignored.
- cmd_valid is never high in WAIT_DONE, CAPTURE, RESULT, FINISH or IDLE. cmd is held at the last value when cmd_valid=0.

## Timing
- Reset (async, rst=1): state=IDLE and every output is 0. This covers busy, sweep_done, cmd, cmd_valid, region, res_valid, all res_* and res_cycles. The abort latch and cur are also cleared.
- All outputs are registered; no combinational input-to-output paths.
- Accepted start at edge N: busy=1 and cmd_valid=1 with cmd=0 from cycle N+1.
- Command handshake: cmd_valid drops on the same edge where cmd_read is sampled high, and the next command is asserted the following cycle. This gives one idle cycle between commands, matching the wrapper's return to its init state.
- done sampled high at edge D: CAPTURE occurs in cycle D+1. Restart cmd_valid is asserted from D+2.
- res_valid rises the cycle after the RESTART cmd_read. The transfer completes on an edge with res_valid & res_ready. res_valid is low the following cycle.
- Empty range: sweep_done pulses at N+2 with no commands issued. busy is high for cycles N+1..N+2.
- Reset mid-operation returns to IDLE immediately, regardless of the wrapper's state. The wrapper is reset by the same system reset.

## Test plan
- Single region, first=last=0x0005, wrapper model done after 20 cycles, counter=64'h1234 -> cmd sequence 0,1,3 with region=5, one record {5, 0x1234, ct, cycles=20}, sweep_done once.
- Range 0x0002..0x0004, res_ready always 1 -> records for regions 2,3,4 in order, then sweep_done; the model sees exactly 9 commands.
- Backpressure: res_ready low for 10 cycles in RESULT -> res_* held stable and no new cmd_valid until the transfer.
- Abort asserted during WAIT_DONE of region 3 of range 2..6 -> region 3 completes and is delivered, no region 4 commands, sweep_done follows.
- Boundary cases:
  - first=0xFFFE, last=0xFFFF -> exactly two records, then IDLE, no wrap.
  - first=7, last=3 -> no commands, sweep_done at N+2.
- Async reset asserted mid-WAIT_DONE and between clock edges -> all outputs 0 immediately; a new start after release runs a clean sweep.
